// File: rtl/regfile_nr2w1_pkg.sv
// Shared constants and sizing helpers for the general-purpose register file.
package regfile_nr2w1_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_NREGS = 32;

  // Index width for a bank of nregs entries; never narrower than one bit.
  function automatic int addr_width(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/regfile_nr2w1_byte_merge.sv
// Combinational byte-lane merge: lanes with mask=1 come from new_word, others from old_word.
module byte_merge
  import regfile_nr2w1_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int NB    = byte_lanes(WIDTH)
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  input  logic [NB-1:0]    byte_en,
  output logic [WIDTH-1:0] merged
);

  for (genvar lane = 0; lane < NB; lane++) begin : g_lane
    assign merged[8*lane +: 8] = byte_en[lane] ? new_word[8*lane +: 8]
                                               : old_word[8*lane +: 8];
  end

endmodule

// File: rtl/regfile_nr2w1.sv
// General-purpose register bank: one byte-enabled write port, two combinational read
// ports, optional write-first forwarding and optional hardwired-zero register 0.
module regfile_nr2w1
  import regfile_nr2w1_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int NREGS    = DEFAULT_NREGS,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = addr_width(NREGS),
  localparam int NB       = byte_lanes(WIDTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [NB-1:0]    WrByteEn,
  input  logic [AW-1:0]    RdAddrA,
  output logic [WIDTH-1:0] RdDataA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataB
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] merged_word;
  logic             wr_drop;
  logic             wr_commit;

  // Same merged word feeds both the stored value and the forwarded read value.
  byte_merge #(.WIDTH(WIDTH)) u_merge (
    .old_word (regs_q[WrAddr]),
    .new_word (WrData),
    .byte_en  (WrByteEn),
    .merged   (merged_word)
  );

  always_comb begin
    wr_drop   = (ZERO_REG != 0) && (WrAddr == '0);
    wr_commit = WrEn && !reset && !wr_drop;
  end

  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_commit) begin
      regs_d[WrAddr] = merged_word;
    end
  end

  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  // Zero register wins over forwarding, forwarding wins over stored contents.
  always_comb begin
    RdDataA = regs_q[RdAddrA];
    if ((ZERO_REG != 0) && (RdAddrA == '0)) begin
      RdDataA = '0;
    end else if ((BYPASS != 0) && wr_commit && (RdAddrA == WrAddr)) begin
      RdDataA = merged_word;
    end
  end

  always_comb begin
    RdDataB = regs_q[RdAddrB];
    if ((ZERO_REG != 0) && (RdAddrB == '0)) begin
      RdDataB = '0;
    end else if ((BYPASS != 0) && wr_commit && (RdAddrB == WrAddr)) begin
      RdDataB = merged_word;
    end
  end

endmodule

// File: tb/tb_regfile_nr2w1.sv
// Directed bench for regfile_nr2w1: four instances (default, no-bypass/no-zero,
// 16x8, 64x32) share address/data buses; expected read values go through a queue.
module tb_regfile_nr2w1;

  logic        CLK;
  logic        reset;
  logic        we_main, we_nb, we_16, we_64;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;

  logic [31:0] rd_a_main, rd_b_main, rd_a_nb, rd_b_nb;
  logic [15:0] rd_a_16, rd_b_16;
  logic [63:0] rd_a_64, rd_b_64;

  typedef struct {
    int          id;
    logic [63:0] ea;
    logic [63:0] eb;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_nr2w1 u_main (
    .CLK(CLK), .reset(reset), .WrEn(we_main), .WrAddr(wr_addr),
    .WrData(wr_data[31:0]), .WrByteEn(wr_be[3:0]),
    .RdAddrA(rd_addr_a), .RdDataA(rd_a_main),
    .RdAddrB(rd_addr_b), .RdDataB(rd_b_main)
  );

  regfile_nr2w1 #(.ZERO_REG(0), .BYPASS(0)) u_nb (
    .CLK(CLK), .reset(reset), .WrEn(we_nb), .WrAddr(wr_addr),
    .WrData(wr_data[31:0]), .WrByteEn(wr_be[3:0]),
    .RdAddrA(rd_addr_a), .RdDataA(rd_a_nb),
    .RdAddrB(rd_addr_b), .RdDataB(rd_b_nb)
  );

  regfile_nr2w1 #(.WIDTH(16), .NREGS(8)) u_w16 (
    .CLK(CLK), .reset(reset), .WrEn(we_16), .WrAddr(wr_addr[2:0]),
    .WrData(wr_data[15:0]), .WrByteEn(wr_be[1:0]),
    .RdAddrA(rd_addr_a[2:0]), .RdDataA(rd_a_16),
    .RdAddrB(rd_addr_b[2:0]), .RdDataB(rd_b_16)
  );

  regfile_nr2w1 #(.WIDTH(64), .NREGS(32)) u_w64 (
    .CLK(CLK), .reset(reset), .WrEn(we_64), .WrAddr(wr_addr),
    .WrData(wr_data), .WrByteEn(wr_be),
    .RdAddrA(rd_addr_a), .RdDataA(rd_a_64),
    .RdAddrB(rd_addr_b), .RdDataB(rd_b_64)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_rd(input int id, input logic [63:0] ea, input logic [63:0] eb,
                           input string nm);
    exp_t e;
    e.id = id; e.ea = ea; e.eb = eb; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic set_write(input logic [4:0] addr, input logic [63:0] data,
                           input logic [7:0] be);
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
  endtask

  task automatic set_read(input logic [4:0] a, input logic [4:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
  endtask

  task automatic idle();
    we_main = 1'b0; we_nb = 1'b0; we_16 = 1'b0; we_64 = 1'b0;
  endtask

  // Scoreboard monitor: drains this cycle's expectations at the falling edge.
  always @(negedge CLK) begin
    exp_t        e;
    logic [63:0] act_a, act_b;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.id)
        0:       begin act_a = {32'b0, rd_a_main}; act_b = {32'b0, rd_b_main}; end
        1:       begin act_a = {32'b0, rd_a_nb};   act_b = {32'b0, rd_b_nb};   end
        2:       begin act_a = {48'b0, rd_a_16};   act_b = {48'b0, rd_b_16};   end
        default: begin act_a = rd_a_64;            act_b = rd_b_64;            end
      endcase
      checks++;
      if (act_a !== e.ea || act_b !== e.eb) begin
        errors++;
        $display("FAIL %s: got A=%h B=%h, expected A=%h B=%h",
                 e.nm, act_a, act_b, e.ea, e.eb);
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    set_write(5'd0, 64'h0, 8'h00);
    set_read(5'd0, 5'd0);
    repeat (2) tick();
    reset = 1'b0;

    // Reset clears: write r5, reset, read back zero
    set_write(5'd5, 64'hDEADBEEF, 8'hFF);
    we_main = 1'b1;
    tick();
    idle();
    set_read(5'd5, 5'd5);
    expect_rd(0, 64'hDEADBEEF, 64'hDEADBEEF, "r5_written");
    tick();
    reset = 1'b1;
    expect_rd(0, 64'hDEADBEEF, 64'hDEADBEEF, "r5_during_reset");
    tick();
    reset = 1'b0;
    expect_rd(0, 64'h0, 64'h0, "r5_after_reset");
    tick();
    for (int i = 0; i < 32; i++) begin
      set_read(5'(i), 5'(31 - i));
      expect_rd(0, 64'h0, 64'h0, "all_zero_after_reset");
      tick();
    end

    // Byte-lane write with bypass; port B on an untouched register
    set_write(5'd3, 64'h11223344, 8'hFF);
    we_main = 1'b1;
    tick();
    set_write(5'd3, 64'hAABBCCDD, 8'h05);
    set_read(5'd3, 5'd4);
    expect_rd(0, 64'h11BB33DD, 64'h0, "byte_lane_bypass");
    tick();
    set_write(5'd3, 64'hFFFFFFFF, 8'h00);
    expect_rd(0, 64'h11BB33DD, 64'h0, "byte_en_zero_noop");
    tick();
    idle();
    set_read(5'd4, 5'd3);
    expect_rd(0, 64'h0, 64'h11BB33DD, "byte_lane_stored");
    tick();

    // Zero register on main; ordinary r0 on the no-zero instance
    set_write(5'd0, 64'hFFFFFFFF, 8'hFF);
    we_main = 1'b1;
    set_read(5'd0, 5'd0);
    expect_rd(0, 64'h0, 64'h0, "zero_reg_same_cycle");
    tick();
    idle();
    expect_rd(0, 64'h0, 64'h0, "zero_reg_after");
    set_write(5'd0, 64'h5A5A5A5A, 8'hFF);
    we_nb = 1'b1;
    tick();
    idle();
    expect_rd(1, 64'h5A5A5A5A, 64'h5A5A5A5A, "r0_plain_register");
    tick();

    // Bypass versus no-bypass on r7
    set_write(5'd7, 64'h12345678, 8'hFF);
    set_read(5'd7, 5'd7);
    we_main = 1'b1;
    we_nb   = 1'b1;
    expect_rd(0, 64'h12345678, 64'h12345678, "bypass_hit_both");
    expect_rd(1, 64'h0, 64'h0, "nobypass_before_edge");
    tick();
    idle();
    expect_rd(0, 64'h12345678, 64'h12345678, "bypass_stored");
    expect_rd(1, 64'h12345678, 64'h12345678, "nobypass_after_edge");
    tick();

    // Reset priority over a write to r9
    reset = 1'b1;
    set_write(5'd9, 64'hCAFEF00D, 8'hFF);
    we_main = 1'b1;
    we_nb   = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    set_read(5'd9, 5'd7);
    expect_rd(0, 64'h0, 64'h0, "reset_beats_write");
    expect_rd(1, 64'h0, 64'h0, "reset_beats_write_nb");
    tick();

    // Sweep: 16x8 and 64x32 instances written with i*0x0101...
    for (int i = 0; i < 32; i++) begin
      set_write(5'(i), 64'(i) * 64'h0101010101010101, 8'hFF);
      we_64 = 1'b1;
      we_16 = (i < 8);
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      set_read(5'(i), 5'(31 - i));
      expect_rd(3, 64'(i) * 64'h0101010101010101,
                64'(31 - i) * 64'h0101010101010101, "sweep_w64");
      if (i < 8) begin
        expect_rd(2, 64'(i) * 64'h0101, 64'(7 - i) * 64'h0101, "sweep_w16");
      end
      tick();
    end

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_nr2w1.md
Name: regfile_nr2w1

Overview:
- Parametrised register bank, the successor to the single 32-bit load-enable register.
- Holds NREGS words of WIDTH bits, with one byte-enabled write port and two combinational read ports.
- Optional write-first bypass and an optional hardwired-zero register 0.
- Sits in the CPU datapath as the general-purpose register file between decode and execute.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- NREGS, 32, number of registers; must be a power of two, at least 2.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to the addressed register is forwarded to the read outputs.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- WrEn  input  1  write request.
- WrAddr  input  log2(NREGS)  write register index.
- WrData  input  WIDTH  write data.
- WrByteEn  input  WIDTH/8  per-byte write mask; bit i covers WrData[8i+7:8i].
- RdAddrA  input  log2(NREGS)  read port A index.
- RdDataA  output  WIDTH  read port A data.
- RdAddrB  input  log2(NREGS)  read port B index.
- RdDataB  output  WIDTH  read port B data.

Behaviour:
- Reset:
  - On a rising edge with reset=1, every register becomes 0.
  - Reset has priority over WrEn; a write presented in a reset cycle is discarded.
  - The block has no initial blocks; state before the first reset is undefined.
- Write:
  - On a rising edge with reset=0 and WrEn=1, register WrAddr is updated.
  - Each byte with WrByteEn[i]=1 takes the matching byte of WrData; bytes with WrByteEn[i]=0 keep their old value.
  - WrEn=1 with WrByteEn all zero is a legal no-op.
- Zero register:
  - With ZERO_REG=1, writes to address 0 are dropped; register 0 stays 0 and reads of address 0 return 0.
  - With ZERO_REG=0, register 0 behaves like any other register.
- Read:
  - Combinational, zero cycles of latency; RdDataX reflects the register contents addressed by RdAddrX.
  - During reset cycles the outputs show the pre-edge contents; they read 0 from the cycle after reset.
- Bypass (BYPASS=1):
  - Applies when WrEn=1, reset=0, RdAddrX==WrAddr and the address is not a dropped zero-register write.
  - RdDataX is then the merged value: new bytes where WrByteEn=1, stored bytes elsewhere.
  - Both ports bypass independently; both may hit at once.
- No bypass (BYPASS=0): reads return stored contents; the new value is visible from the next cycle.
- Simultaneous events:
  - RdAddrA==RdAddrB returns identical data on both ports.
  - A write and reads of different addresses in the same cycle do not interact.
- Addresses are full-range; no out-of-range case exists because NREGS is a power of two.
- The block raises no errors and has no handshake; the caller owns hazards beyond the bypass.

Decomposition:
- Shared package constants: default WIDTH and NREGS, the address-width function (clog2) and the byte-lane count WIDTH/8.
- Sub-module byte_merge (combinational): takes old word, new word and byte mask, returns the merged word.
- byte_merge is instantiated once in the write path and reused as the bypass value, so the stored and forwarded results are identical by construction.
- Storage is a register array inside regfile_nr2w1; no memory macro.

Test Plan:
1. Reset → clear: write 0xDEADBEEF to r5, then pulse reset one cycle → RdAddrA=5 gives 0x00000000 the next cycle; every register reads 0.
2. Byte-lane write: r3 holds 0x11223344; write 0xAABBCCDD with WrByteEn=4'b0101 → r3 reads 0x11BB33DD.
3. Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0 with all byte enables set → r0 reads 0 on both ports, in the same cycle and afterwards.
4. Bypass: BYPASS=1, r7 holds 0x0; in the same cycle write 0x12345678 to r7 with RdAddrA=RdAddrB=7 → both ports show 0x12345678 before the edge.
   - Repeat with BYPASS=0 → both show 0x0 before the edge and 0x12345678 after it.
5. Reset priority: WrEn=1 to r9 with data 0xCAFEF00D in the same cycle as reset=1 → r9 reads 0 the next cycle.
6. Sweep: write each register i with value i*0x01010101, then read all pairs (i, NREGS-1-i) on A and B → every value matches.
   - Run for WIDTH=16/NREGS=8 and WIDTH=64/NREGS=32.
